// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU op codes, forward selects and
// the multiplier FSM state type.
package ex_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;

  // 2'b11 is not a valid select and falls back to the register file
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ex_state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial-product step per cycle,
// XLEN steps, full 2*XLEN product held in prod.
//
// state | meaning
// IDLE  | waiting for start; operands latched on the start edge
// BUSY  | one shift-add iteration per cycle, XLEN cycles
// DONE  | prod holds the final product for this one cycle
module mul_iter
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*XLEN-1:0] prod
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  ex_state_e       state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] mcand;
  logic [XLEN:0]   sum;

  // prod = {accumulator, remaining multiplier bits}; the low bit picks the add
  assign sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      mcand <= '0;
      prod  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            mcand <= a;
            prod  <= {{XLEN{1'b0}}, b};
            cnt   <= '0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            prod <= {sum, prod[XLEN-1:1]};
            cnt  <= cnt + CW'(1);
            if (cnt == LAST) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_BUSY);
  assign done = (state == ST_DONE);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU and the EX/MEM register.
// Build macro EX_MUL_EN adds the iterative multiplier and its pipeline stall.
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [4:0]      ex_rs1,
  input  logic [4:0]      ex_rs2,
  input  logic [XLEN-1:0] ex_rs1_data,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ex_alu_src,
  input  logic [3:0]      ex_alu_op,
  input  logic [4:0]      ex_rd,
  input  logic            ex_regwrite,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic [XLEN-1:0] wb_fwd_data,
  input  logic            flush,
  output logic            stall_req,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_result,
  output logic [XLEN-1:0] mem_rs2_data,
  output logic [4:0]      mem_rd,
  output logic            mem_regwrite
);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] wr_result;
  logic [4:0]      shamt;
  logic            wr_en;
  logic            unused_idx;

  // Register indices only feed the forwarding unit outside this block
  assign unused_idx = ^{ex_rs1, ex_rs2};

  function automatic logic [XLEN-1:0] fwd_sel(input logic [1:0]      sel,
                                              input logic [XLEN-1:0] rf,
                                              input logic [XLEN-1:0] mem,
                                              input logic [XLEN-1:0] wb);
    case (sel)
      FWD_MEM: return mem;
      FWD_WB:  return wb;
      default: return rf;
    endcase
  endfunction

  assign op_a  = fwd_sel(forward_a, ex_rs1_data, mem_fwd_data, wb_fwd_data);
  assign fwd_b = fwd_sel(forward_b, ex_rs2_data, mem_fwd_data, wb_fwd_data);
  assign op_b  = ex_alu_src ? ex_imm : fwd_b;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = '0;
    case (ex_alu_op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $signed(op_a) >>> shamt;
      OP_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
      OP_SLTU: alu_res = XLEN'(op_a < op_b);
      default: alu_res = '0;
    endcase
  end

`ifdef EX_MUL_EN
  logic              mul_busy;
  logic              mul_done;
  logic              mul_idle;
  logic              mul_start;
  logic [2*XLEN-1:0] mul_prod;

  assign mul_idle  = !mul_busy && !mul_done;
  assign mul_start = mul_idle && ex_valid && is_mul_op(ex_alu_op) && !flush;
  assign stall_req = rst_n && !flush && (mul_start || mul_busy);

  // Operands are captured on the issue edge because MEM/WB drain during the stall
  mul_iter #(.XLEN(XLEN)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .abort (flush),
    .a     (op_a),
    .b     (op_b),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  // In DONE the mul is still in ID/EX; writing from DONE alone keeps it from re-issuing
  assign wr_en = !flush &&
                 (mul_done || (mul_idle && ex_valid && !is_mul_op(ex_alu_op)));
  assign wr_result = !mul_done                 ? alu_res :
                     (ex_alu_op == OP_MULHU)   ? mul_prod[2*XLEN-1:XLEN] :
                                                 mul_prod[XLEN-1:0];
`else
  assign stall_req = 1'b0;
  assign wr_en     = !flush && ex_valid;
  assign wr_result = is_mul_op(ex_alu_op) ? '0 : alu_res;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid    <= 1'b0;
      mem_result   <= '0;
      mem_rs2_data <= '0;
      mem_rd       <= '0;
      mem_regwrite <= 1'b0;
    end else if (wr_en) begin
      mem_valid    <= 1'b1;
      mem_result   <= wr_result;
      mem_rs2_data <= fwd_b;
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;
    end else begin
      mem_valid    <= 1'b0;
      mem_regwrite <= 1'b0;
    end
  end

endmodule
